vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be listed as name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
REQ-002 Ports SHALL be listed as name, direction, width, meaning.
- iCLK, in, 1, single 50 MHz clock for all logic
- iRST, in, 1, synchronous active-high reset
- pix_en, out, 1, pixel strobe: high on the second iCLK of each 25 MHz pixel
- pixel_count, out, 10, horizontal position 0..H_TOTAL-1
- line_count, out, 10, vertical position 0..V_TOTAL-1
- VGA_H_SYNC, out, 1, horizontal sync, active low
- VGA_V_SYNC, out, 1, vertical sync, active low
- video_on, out, 1, high inside the visible region
- frame_start, out, 1, one-iCLK pulse at the first pixel of a frame

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-004 pix_en SHALL toggle on every iCLK edge outside reset.
REQ-005 Counters SHALL advance only on an iCLK edge where pix_en is 1, so each count value is held for 2 iCLK.
REQ-006 pixel_count SHALL increment by 1 and wrap from H_TOTAL-1 to 0.
REQ-007 line_count SHALL increment only when pixel_count wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same edge.
REQ-008 VGA_H_SYNC SHALL be 0 exactly when pixel_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), and 1 otherwise.
REQ-009 VGA_V_SYNC SHALL be 0 exactly when line_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines, and 1 otherwise.
REQ-010 video_on SHALL be 1 exactly when pixel_count < H_ACTIVE and line_count < V_ACTIVE.
REQ-011 frame_start SHALL be 1 only in the iCLK cycle where pix_en=1, pixel_count=0 and line_count=0.
REQ-012 All outputs SHALL be registered.
- VGA_H_SYNC, VGA_V_SYNC, video_on and frame_start SHALL be decoded from the next count values, so they are cycle-aligned with pixel_count and line_count (zero relative latency).
REQ-013 Counters SHALL never hold a value at or above their total; any such value SHALL be forced to 0 on the next advance.

Reset
REQ-014 While iRST=1 at an iCLK edge, the following SHALL hold:
- pix_en=0, pixel_count=0, line_count=0
- VGA_H_SYNC=1, VGA_V_SYNC=1, video_on=0, frame_start=0
REQ-015 On the first iCLK edge after iRST falls, the outputs SHALL be:
- pix_en=1, counts remain (0,0), video_on=1, frame_start=1
- Pixel (0,0) is therefore held for only 1 iCLK; every later pixel is held for 2.
REQ-016 Reset asserted mid-line or mid-frame SHALL abandon the current frame with no partial sync pulse after release.

Structure
REQ-017 The timing defaults, H_TOTAL, V_TOTAL and the sync start/end constants SHALL live in the shared package vga_timing_pkg, which the display generators also use.
REQ-018 One sub-module, vga_axis_counter, SHALL be used.
- It is a wrap counter with a carry output.
- It is instantiated twice: horizontal, and vertical with its enable driven by the horizontal carry.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Hold iRST for 5 cycles, then release -> all REQ-014 values during reset; cycle 1 after release has pix_en=1, video_on=1, frame_start=1.
- Free-run one line -> consecutive pixel_count wraps exactly 1600 iCLK apart; video_on high for 1280 iCLK per visible line.
- Horizontal sync -> VGA_H_SYNC falls when pixel_count becomes 656 and rises when it becomes 752; low for 192 iCLK.
- Vertical sync -> VGA_V_SYNC low for lines 490-491 only, i.e. 3200 iCLK; line_count wraps 524->0 together with pixel_count 799->0.
- Full frame -> frame_start pulses exactly 840000 iCLK apart; 307200 pix_en cycles with video_on=1 per frame.
- Assert iRST at pixel_count=700, line_count=491 (during both syncs) -> both syncs go to 1 at the reset edge; next frame_start occurs 1 iCLK after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and a small decode
// helper. The display generators use the same package, so they agree on totals.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // True when a count lies inside the inclusive window [lo, hi].
  function automatic logic in_window(input logic [COUNT_W-1:0] value,
                                     input int lo, input int hi);
    return (int'(value) >= lo) && (int'(value) <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster scan: counts 0..TOTAL-1 while enabled and wraps.
// count_next is exposed so the caller can decode registered outputs that line
// up with count itself. carry is high on the enabled cycle that wraps.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  // Next value: wrap at LAST; any out-of-range value also collapses to zero.
  always_comb begin
    carry      = en && (count >= LAST);
    count_next = count;
    if (en) begin
      count_next = carry ? '0 : count + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator running from a 50 MHz clock with a 25 MHz pixel strobe.
// Counters step on cycles where pix_en is high, so every pixel spans two
// clocks; sync, video_on and frame_start are decoded from the counters' next
// values and registered, so they stay aligned with pixel_count/line_count.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  output logic               pix_en,
  output logic [COUNT_W-1:0] pixel_count,
  output logic [COUNT_W-1:0] line_count,
  output logic               VGA_H_SYNC,
  output logic               VGA_V_SYNC,
  output logic               video_on,
  output logic               frame_start
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic [COUNT_W-1:0] H_ACTIVE_C = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACTIVE_C = COUNT_W'(V_ACTIVE);

  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;
  logic               h_carry;
  // End-of-frame carry; nothing downstream needs it at present.
  logic               v_carry_unused;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (COUNT_W)
  ) u_h_counter (
    .clk        (iCLK),
    .rst        (iRST),
    .en         (pix_en),
    .count      (pixel_count),
    .count_next (h_next),
    .carry      (h_carry)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (COUNT_W)
  ) u_v_counter (
    .clk        (iCLK),
    .rst        (iRST),
    .en         (h_carry),
    .count      (line_count),
    .count_next (v_next),
    .carry      (v_carry_unused)
  );

  // Pixel strobe and decoded outputs, registered from the next count values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pix_en      <= 1'b0;
      VGA_H_SYNC  <= 1'b1;
      VGA_V_SYNC  <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      VGA_H_SYNC  <= ~in_window(h_next, H_SYNC_START, H_SYNC_END);
      VGA_V_SYNC  <= ~in_window(v_next, V_SYNC_START, V_SYNC_END);
      video_on    <= (h_next < H_ACTIVE_C) && (v_next < V_ACTIVE_C);
      frame_start <= ~pix_en && (h_next == '0) && (v_next == '0);
    end
  end

endmodule
